// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX stage: control bundle, operand/next-pc encodings.
// Optional statistics counters are built when ID_EX_STATS_EN is defined.
package id_ex_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC2_RS2  = 2'b00,
    SRC2_IMM  = 2'b01,
    SRC2_FOUR = 2'b11
  } src2_e;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'b00,
    NPC_PCIMM  = 2'b01,
    NPC_RS1IMM = 2'b11
  } npc_e;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src1;
    logic       reg_write;
    logic       branch;
    logic       invert_branch;
    logic       jump;
    logic       bit_exit;
    logic [1:0] alu_src2;
    logic [1:0] type_instr;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Bubble keeps stale payload but drops anything with an architectural effect.
  function automatic ctrl_t ctrl_kill(input ctrl_t c);
    ctrl_t k;
    k           = c;
    k.reg_write = 1'b0;
    k.mem_write = 1'b0;
    k.branch    = 1'b0;
    k.jump      = 1'b0;
    k.bit_exit  = 1'b0;
    return k;
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use hazard compare between the EX-resident load
// and the instruction currently presented by the decoder.
module hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int REGIDX_W = 5
) (
  input  logic                i_ex_valid,
  input  logic                i_ex_mem_to_reg,
  input  logic                i_ex_reg_write,
  input  logic [REGIDX_W-1:0] i_ex_rd,
  input  logic                i_id_live,
  input  logic [REGIDX_W-1:0] i_id_rs1,
  input  logic [REGIDX_W-1:0] i_id_rs2,
  input  logic                i_id_alu_src1,
  input  logic [1:0]          i_id_alu_src2,
  input  logic                i_id_mem_write,
  output logic                o_hazard
);

  logic w_ex_load;
  logic w_use_rs1;
  logic w_use_rs2;

  assign w_ex_load = i_ex_valid & i_ex_mem_to_reg
                   & i_ex_reg_write
                   & (i_ex_rd != '0);

  // rs1 counts as read whenever src1 selects the register (LUI may false-stall).
  assign w_use_rs1 = (i_id_rs1 == i_ex_rd)
                   & ~i_id_alu_src1;

  assign w_use_rs2 = (i_id_rs2 == i_ex_rd)
                   & ((i_id_alu_src2 == SRC2_RS2)
                      | i_id_mem_write);

  assign o_hazard = w_ex_load & i_id_live
                  & (w_use_rs1 | w_use_rs2);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubbles, flush and sticky halt.
// Define ID_EX_STATS_EN to build the stall/flush statistics counters.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REGIDX_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                dec_valid,
  input  logic [3:0]          dec_alu_op,
  input  logic                dec_mem_to_reg,
  input  logic                dec_mem_write,
  input  logic                dec_alu_src1,
  input  logic                dec_reg_write,
  input  logic                dec_branch,
  input  logic                dec_invert_branch,
  input  logic                dec_jump,
  input  logic                dec_bit_exit,
  input  logic [1:0]          dec_alu_src2,
  input  logic [1:0]          dec_type_instr,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [XLEN-1:0]     in_rs1_data,
  input  logic [XLEN-1:0]     in_rs2_data,
  input  logic [XLEN-1:0]     in_imm,
  input  logic [REGIDX_W-1:0] in_rs1,
  input  logic [REGIDX_W-1:0] in_rs2,
  input  logic [REGIDX_W-1:0] in_rd,
  input  logic                flush,
  input  logic                ex_stall,
  output logic                in_ready,
  output logic                out_valid,
  output logic [3:0]          out_alu_op,
  output logic                out_mem_to_reg,
  output logic                out_mem_write,
  output logic                out_alu_src1,
  output logic                out_reg_write,
  output logic                out_branch,
  output logic                out_invert_branch,
  output logic                out_jump,
  output logic                out_bit_exit,
  output logic [1:0]          out_alu_src2,
  output logic [1:0]          out_type_instr,
  output logic [XLEN-1:0]     out_pc,
  output logic [XLEN-1:0]     out_rs1_data,
  output logic [XLEN-1:0]     out_rs2_data,
  output logic [XLEN-1:0]     out_imm,
  output logic [REGIDX_W-1:0] out_rs1,
  output logic [REGIDX_W-1:0] out_rs2,
  output logic [REGIDX_W-1:0] out_rd,
  output logic                halted,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         flush_cnt
);

  ctrl_t               r_ctrl;
  logic                r_valid;
  logic                r_halted;
  logic [XLEN-1:0]     r_pc;
  logic [XLEN-1:0]     r_rs1_data;
  logic [XLEN-1:0]     r_rs2_data;
  logic [XLEN-1:0]     r_imm;
  logic [REGIDX_W-1:0] r_rs1;
  logic [REGIDX_W-1:0] r_rs2;
  logic [REGIDX_W-1:0] r_rd;

  ctrl_t w_dec_ctrl;
  logic  w_live;
  logic  w_hazard;
  logic  w_bubble;
  logic  w_kill;
  logic  w_load;

  assign w_dec_ctrl = '{
    alu_op:        dec_alu_op,
    mem_to_reg:    dec_mem_to_reg,
    mem_write:     dec_mem_write,
    alu_src1:      dec_alu_src1,
    reg_write:     dec_reg_write,
    branch:        dec_branch,
    invert_branch: dec_invert_branch,
    jump:          dec_jump,
    bit_exit:      dec_bit_exit,
    alu_src2:      dec_alu_src2,
    type_instr:    dec_type_instr
  };

  assign w_live = in_valid & dec_valid & ~r_halted;

  hazard_detect #(
    .REGIDX_W (REGIDX_W)
  ) u_hazard (
    .i_ex_valid      (r_valid),
    .i_ex_mem_to_reg (r_ctrl.mem_to_reg),
    .i_ex_reg_write  (r_ctrl.reg_write),
    .i_ex_rd         (r_rd),
    .i_id_live       (w_live),
    .i_id_rs1        (in_rs1),
    .i_id_rs2        (in_rs2),
    .i_id_alu_src1   (dec_alu_src1),
    .i_id_alu_src2   (dec_alu_src2),
    .i_id_mem_write  (dec_mem_write),
    .o_hazard        (w_hazard)
  );

  // Edge priority: flush > ex_stall > hazard/halt bubble > capture.
  assign w_bubble = ~flush & ~ex_stall
                  & (w_hazard | r_halted);
  assign w_kill   = flush | w_bubble;
  assign w_load   = ~flush & ~ex_stall
                  & ~w_hazard & ~r_halted;

  assign in_ready = ~ex_stall & ~w_hazard
                  & ~r_halted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
      r_ctrl     <= CTRL_NOP;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
    end else begin
      if (w_kill) begin
        r_valid <= 1'b0;
        r_ctrl  <= ctrl_kill(r_ctrl);
      end else if (w_load) begin
        r_valid    <= w_live;
        r_ctrl     <= w_dec_ctrl;
        r_pc       <= in_pc;
        r_rs1_data <= in_rs1_data;
        r_rs2_data <= in_rs2_data;
        r_imm      <= in_imm;
        r_rs1      <= in_rs1;
        r_rs2      <= in_rs2;
        r_rd       <= in_rd;
      end
      if (w_load & w_live & dec_bit_exit)
        r_halted <= 1'b1;
    end
  end

`ifdef ID_EX_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_bubble & w_hazard)
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (flush)
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

  assign out_valid         = r_valid;
  assign halted            = r_halted;
  assign out_alu_op        = r_ctrl.alu_op;
  assign out_mem_to_reg    = r_ctrl.mem_to_reg;
  assign out_mem_write     = r_ctrl.mem_write;
  assign out_alu_src1      = r_ctrl.alu_src1;
  assign out_reg_write     = r_ctrl.reg_write;
  assign out_branch        = r_ctrl.branch;
  assign out_invert_branch = r_ctrl.invert_branch;
  assign out_jump          = r_ctrl.jump;
  assign out_bit_exit      = r_ctrl.bit_exit;
  assign out_alu_src2      = r_ctrl.alu_src2;
  assign out_type_instr    = r_ctrl.type_instr;
  assign out_pc            = r_pc;
  assign out_rs1_data      = r_rs1_data;
  assign out_rs2_data      = r_rs2_data;
  assign out_imm           = r_imm;
  assign out_rs1           = r_rs1;
  assign out_rs2           = r_rs2;
  assign out_rd            = r_rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed test-plan scenarios
// followed by randomized traffic against a behavioural model.
module tb_id_ex_stage;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic        mem_to_reg;
    logic        mem_write;
    logic        alu_src1;
    logic        reg_write;
    logic        branch;
    logic        invert_branch;
    logic        jump;
    logic        bit_exit;
    logic [1:0]  alu_src2;
    logic [1:0]  type_instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic dec_valid = 1'b0;
  logic flush = 1'b0;
  logic ex_stall = 1'b0;
  rec_t d = '0;

  logic        in_ready, out_valid, halted;
  logic [3:0]  out_alu_op;
  logic        out_mem_to_reg, out_mem_write, out_alu_src1;
  logic        out_reg_write, out_branch, out_invert_branch;
  logic        out_jump, out_bit_exit;
  logic [1:0]  out_alu_src2, out_type_instr;
  logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] stall_cnt, flush_cnt;
  rec_t        o_rec;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .dec_valid         (dec_valid),
    .dec_alu_op        (d.alu_op),
    .dec_mem_to_reg    (d.mem_to_reg),
    .dec_mem_write     (d.mem_write),
    .dec_alu_src1      (d.alu_src1),
    .dec_reg_write     (d.reg_write),
    .dec_branch        (d.branch),
    .dec_invert_branch (d.invert_branch),
    .dec_jump          (d.jump),
    .dec_bit_exit      (d.bit_exit),
    .dec_alu_src2      (d.alu_src2),
    .dec_type_instr    (d.type_instr),
    .in_pc             (d.pc),
    .in_rs1_data       (d.rs1_data),
    .in_rs2_data       (d.rs2_data),
    .in_imm            (d.imm),
    .in_rs1            (d.rs1),
    .in_rs2            (d.rs2),
    .in_rd             (d.rd),
    .flush             (flush),
    .ex_stall          (ex_stall),
    .in_ready          (in_ready),
    .out_valid         (out_valid),
    .out_alu_op        (out_alu_op),
    .out_mem_to_reg    (out_mem_to_reg),
    .out_mem_write     (out_mem_write),
    .out_alu_src1      (out_alu_src1),
    .out_reg_write     (out_reg_write),
    .out_branch        (out_branch),
    .out_invert_branch (out_invert_branch),
    .out_jump          (out_jump),
    .out_bit_exit      (out_bit_exit),
    .out_alu_src2      (out_alu_src2),
    .out_type_instr    (out_type_instr),
    .out_pc            (out_pc),
    .out_rs1_data      (out_rs1_data),
    .out_rs2_data      (out_rs2_data),
    .out_imm           (out_imm),
    .out_rs1           (out_rs1),
    .out_rs2           (out_rs2),
    .out_rd            (out_rd),
    .halted            (halted),
    .stall_cnt         (stall_cnt),
    .flush_cnt         (flush_cnt)
  );

  assign o_rec = {out_alu_op, out_mem_to_reg, out_mem_write,
                  out_alu_src1, out_reg_write, out_branch,
                  out_invert_branch, out_jump, out_bit_exit,
                  out_alu_src2, out_type_instr, out_pc,
                  out_rs1_data, out_rs2_data, out_imm,
                  out_rs1, out_rs2, out_rd};

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: what the EX side should be holding.
  rec_t        m;
  logic        m_valid, m_halted, m_killed;
  logic [31:0] m_scnt, m_fcnt;

  task automatic chk(input string tag,
                     input logic [159:0] obs,
                     input logic [159:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)",
               tag, obs, exp, $time);
    end
  endtask

  function automatic rec_t kill(input rec_t r);
    rec_t k = r;
    k.reg_write = 1'b0;
    k.mem_write = 1'b0;
    k.branch    = 1'b0;
    k.jump      = 1'b0;
    k.bit_exit  = 1'b0;
    return k;
  endfunction

  task automatic check_out();
    logic [31:0] es, ef;
`ifdef ID_EX_STATS_EN
    es = m_scnt;
    ef = m_fcnt;
`else
    es = 32'd0;
    ef = 32'd0;
`endif
    chk("out_valid", out_valid, m_valid);
    chk("halted", halted, m_halted);
    if (m_valid)
      chk("fields", o_rec, m);
    else if (m_killed)
      chk("bubble_ctl", {out_reg_write, out_mem_write,
          out_branch, out_jump, out_bit_exit}, 5'b0);
    chk("stall_cnt", stall_cnt, es);
    chk("flush_cnt", flush_cnt, ef);
  endtask

  task automatic do_rst();
    rst = 1'b1;
    #2;
    m = '0;
    m_valid = 0;
    m_halted = 0;
    m_killed = 0;
    m_scnt = 0;
    m_fcnt = 0;
    check_out();
    chk("rst_fields", o_rec, 160'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: check in_ready before the edge, then outputs after it.
  task automatic cyc();
    logic live, haz;
    #1;
    live = in_valid && dec_valid && !m_halted;
    haz = m_valid && m.mem_to_reg && m.reg_write
       && (m.rd != 0) && live
       && ((d.rs1 == m.rd && !d.alu_src1)
        || (d.rs2 == m.rd
            && (d.alu_src2 == 2'b00 || d.mem_write)));
    chk("in_ready", in_ready, !ex_stall && !haz && !m_halted);
    @(posedge clk);
    if (flush) begin
      m_valid = 0;
      m = kill(m);
      m_killed = 1;
      m_fcnt = m_fcnt + 1;
    end else if (!ex_stall) begin
      if (haz || m_halted) begin
        m_valid = 0;
        m = kill(m);
        m_killed = 1;
        if (haz) m_scnt = m_scnt + 1;
      end else begin
        m = d;
        m_valid = live;
        m_killed = 0;
        if (live && d.bit_exit) m_halted = 1;
      end
    end
    #1;
    check_out();
  endtask

  task automatic ins(input logic [3:0] op,
                     input logic m2r, input logic mw,
                     input logic rw, input logic s1,
                     input logic [1:0] s2, input logic ex,
                     input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] rd);
    in_valid = 1;
    dec_valid = 1;
    d = '0;
    d.alu_op = op;
    d.mem_to_reg = m2r;
    d.mem_write = mw;
    d.reg_write = rw;
    d.alu_src1 = s1;
    d.alu_src2 = s2;
    d.bit_exit = ex;
    d.rs1 = r1;
    d.rs2 = r2;
    d.rd = rd;
    d.pc = $urandom;
    d.rs1_data = $urandom;
    d.rs2_data = $urandom;
    d.imm = $urandom;
  endtask

  task automatic rnd(input bit allow_exit);
    logic [1:0] s2sel;
    in_valid = ($urandom_range(0, 9) != 0);
    dec_valid = ($urandom_range(0, 9) != 0);
    d = '0;
    d.alu_op = 4'($urandom_range(0, 10));
    d.mem_to_reg = ($urandom_range(0, 4) < 2);
    d.mem_write = ($urandom_range(0, 5) == 0);
    d.reg_write = ($urandom_range(0, 9) < 7);
    d.alu_src1 = ($urandom_range(0, 4) == 0);
    s2sel = 2'($urandom_range(0, 2));
    d.alu_src2 = (s2sel == 2) ? 2'b11 : s2sel;
    d.type_instr = 2'($urandom_range(0, 3));
    d.branch = ($urandom_range(0, 7) == 0);
    d.invert_branch = 1'($urandom);
    d.jump = ($urandom_range(0, 9) == 0);
    d.bit_exit = allow_exit && ($urandom_range(0, 59) == 0);
    d.rs1 = 5'($urandom_range(0, 3));
    d.rs2 = 5'($urandom_range(0, 3));
    d.rd = 5'($urandom_range(0, 3));
    d.pc = $urandom;
    d.rs1_data = $urandom;
    d.rs2_data = $urandom;
    d.imm = $urandom;
    flush = ($urandom_range(0, 9) == 0);
    ex_stall = ($urandom_range(0, 4) == 0);
  endtask

  initial begin
    do_rst();
    // ADD x3,x1,x2 then ADDI x4,x1,5
    ins(4'd0, 0, 0, 1, 0, 2'b00, 0, 5'd1, 5'd2, 5'd3); cyc();
    ins(4'd0, 0, 0, 1, 0, 2'b01, 0, 5'd1, 5'd9, 5'd4); cyc();
    in_valid = 0; cyc();
    // LW x5 then dependent ADD x6,x5,x7
    ins(4'd0, 1, 0, 1, 0, 2'b01, 0, 5'd2, 5'd0, 5'd5); cyc();
    ins(4'd0, 0, 0, 1, 0, 2'b00, 0, 5'd5, 5'd7, 5'd6); cyc(); cyc();
    in_valid = 0; cyc();
    // LW x0 then ADD reading x0
    ins(4'd0, 1, 0, 1, 0, 2'b01, 0, 5'd1, 5'd0, 5'd0); cyc();
    ins(4'd0, 0, 0, 1, 0, 2'b00, 0, 5'd0, 5'd0, 5'd6); cyc();
    // LW x5 then ADDI whose rs2 field is 5
    ins(4'd0, 1, 0, 1, 0, 2'b01, 0, 5'd1, 5'd0, 5'd5); cyc();
    ins(4'd0, 0, 0, 1, 0, 2'b01, 0, 5'd1, 5'd5, 5'd6); cyc();
    // flush with ADD presented
    ins(4'd0, 0, 0, 1, 0, 2'b00, 0, 5'd1, 5'd2, 5'd3);
    flush = 1; cyc(); flush = 0;
    // ex_stall held 3 cycles over a live instruction
    ins(4'd1, 0, 0, 1, 0, 2'b00, 0, 5'd1, 5'd2, 5'd8); cyc();
    ins(4'd5, 0, 0, 1, 0, 2'b00, 0, 5'd3, 5'd4, 5'd9);
    ex_stall = 1; repeat (3) cyc(); ex_stall = 0; cyc();
    // hazard under ex_stall: bubble waits for stall release
    ins(4'd0, 1, 0, 1, 0, 2'b01, 0, 5'd2, 5'd0, 5'd5); cyc();
    ins(4'd0, 0, 0, 1, 0, 2'b00, 0, 5'd5, 5'd7, 5'd6);
    ex_stall = 1; repeat (2) cyc(); ex_stall = 0; cyc(); cyc();
    // flush together with hazard
    ins(4'd0, 1, 0, 1, 0, 2'b01, 0, 5'd2, 5'd0, 5'd5); cyc();
    ins(4'd0, 0, 0, 1, 0, 2'b00, 0, 5'd5, 5'd7, 5'd6);
    flush = 1; cyc(); flush = 0; cyc();
    // flush together with exit capture
    ins(4'd0, 0, 0, 0, 0, 2'b00, 1, 5'd0, 5'd0, 5'd0);
    flush = 1; cyc(); flush = 0; in_valid = 0; cyc();
    // exit, drain, halted behaviour, flush while halted
    ins(4'd0, 0, 0, 0, 0, 2'b00, 1, 5'd0, 5'd0, 5'd0); cyc();
    ins(4'd0, 0, 0, 1, 0, 2'b00, 0, 5'd1, 5'd2, 5'd3);
    repeat (3) cyc();
    flush = 1; cyc(); flush = 0; cyc();
    do_rst();
    // reset during a stall
    ins(4'd0, 0, 0, 1, 0, 2'b00, 0, 5'd1, 5'd2, 5'd3); cyc();
    ex_stall = 1; cyc();
    do_rst();
    ex_stall = 0;
    // randomized traffic, occasional exits and resets
    for (int k = 0; k < 800; k++) begin
      rnd(k >= 300);
      cyc();
      if ($urandom_range(0, 59) == 0) begin
        flush = 0;
        ex_stall = 0;
        do_rst();
      end
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
